// File: rtl/operand_sequencer.sv
// operand_sequencer
//   Buffers operand words in an 8-entry FIFO. It replays them to the downstream
//   ALU stage as frames. Each frame starts with an all-zero header beat, which
//   the downstream stage consumes on its own IDLE-to-COLLECT transition. The
//   payload beats follow, one per edge, while words are available. After the
//   last beat the block waits for the downstream result strobe. A 4-bit
//   watchdog bounds that wait.
//
// Ports
//   clk                in   rising-edge clock
//   rst_n              in   asynchronous active-low reset
//   in_valid           in   upstream word present
//   in_ready           out  FIFO not full
//   in_a, in_b         in   8-bit operands of the word
//   in_instr           in   4-bit opcode of the word
//   in_last            in   word closes its frame
//   down_result_valid  in   downstream result strobe (only honoured in WAIT)
//   A, B               out  registered operands
//   instruction        out  registered opcode
//   data_valid         out  registered beat strobe
//   last_data          out  registered final-beat marker
//   busy               out  FSM is not idle
//   frame_count        out  frames acknowledged downstream, wraps at 256
//   err                out  sticky watchdog timeout flag

module operand_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic [3:0] in_instr,
  input  logic       in_last,
  input  logic       down_result_valid,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [3:0] instruction,
  output logic       data_valid,
  output logic       last_data,
  output logic       busy,
  output logic [7:0] frame_count,
  output logic       err
);

  localparam int unsigned Depth     = 8;
  localparam int unsigned PtrW      = 3;
  localparam int unsigned CntW      = 4;
  localparam int unsigned WordW     = 21;
  localparam logic [3:0]  WdLimit   = 4'd15;

  typedef enum logic [1:0] {
    StIdle,
    StPayload,
    StWait
  } state_e;

  state_e state;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  // Word layout: [20:13] a, [12:5] b, [4:1] instr, [0] last.
  logic [WordW-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;

  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic [WordW-1:0] rd_word;
  logic [WordW-1:0] wr_word;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CntW'(Depth));

  // Full blocks the push even on a popping edge. This keeps the occupancy
  // logic free of a pop-to-ready combinational path.
  assign in_ready = ~fifo_full;
  assign push     = in_valid & ~fifo_full;

  // Only PAYLOAD consumes words. The occupancy count is registered, so a word
  // pushed on one edge cannot be popped before the following edge.
  assign pop      = (state == StPayload) & ~fifo_empty;

  assign wr_word  = {in_a, in_b, in_instr, in_last};
  assign rd_word  = mem[rd_ptr];

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered beat outputs
  // ---------------------------------------------------------------------------
  logic [3:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      A           <= '0;
      B           <= '0;
      instruction <= '0;
      data_valid  <= 1'b0;
      last_data   <= 1'b0;
      frame_count <= '0;
      err         <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      case (state)
        StIdle: begin
          last_data <= 1'b0;
          if (!fifo_empty) begin
            // Header beat: zeros with the strobe set. Nothing is popped here.
            state       <= StPayload;
            data_valid  <= 1'b1;
            A           <= '0;
            B           <= '0;
            instruction <= '0;
          end else begin
            data_valid  <= 1'b0;
          end
        end

        StPayload: begin
          if (!fifo_empty) begin
            data_valid  <= 1'b1;
            A           <= rd_word[20:13];
            B           <= rd_word[12:5];
            instruction <= rd_word[4:1];
            last_data   <= rd_word[0];
            if (rd_word[0]) begin
              state  <= StWait;
              wd_cnt <= '0;
            end
          end else begin
            // Gap inside a frame: drop the strobe and keep the operands.
            data_valid <= 1'b0;
            last_data  <= 1'b0;
          end
        end

        StWait: begin
          data_valid <= 1'b0;
          last_data  <= 1'b0;
          if (down_result_valid) begin
            state       <= StIdle;
            frame_count <= frame_count + 8'd1;
          end else if (wd_cnt == WdLimit) begin
            // Timeout: record it and recover without acknowledging the frame.
            state <= StIdle;
            err   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 4'd1;
          end
        end

        default: begin
          state      <= StIdle;
          data_valid <= 1'b0;
          last_data  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != StIdle);

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer. Inputs are driven 1 time unit after
// each rising edge. Outputs are sampled at the same point. Expected values are
// worked out by hand from the frame protocol.

module tb_operand_sequencer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [3:0] in_instr;
  logic       in_last;
  logic       down_result_valid;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] instruction;
  logic       data_valid;
  logic       last_data;
  logic       busy;
  logic [7:0] frame_count;
  logic       err;

  int n_cmp = 0;
  int n_err = 0;

  operand_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_a              (in_a),
    .in_b              (in_b),
    .in_instr          (in_instr),
    .in_last           (in_last),
    .down_result_valid (down_result_valid),
    .A                 (A),
    .B                 (B),
    .instruction       (instruction),
    .data_valid        (data_valid),
    .last_data         (last_data),
    .busy              (busy),
    .frame_count       (frame_count),
    .err               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                          input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_instr = op;
    in_last  = last;
  endtask

  task automatic check_beat(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] op, input logic last);
    check({tag, "_dv"},   32'(data_valid),  32'd1);
    check({tag, "_a"},    32'(A),           32'(a));
    check({tag, "_b"},    32'(B),           32'(b));
    check({tag, "_op"},   32'(instruction), 32'(op));
    check({tag, "_last"}, 32'(last_data),   32'(last));
  endtask

  task automatic pulse_result();
    down_result_valid = 1'b1;
    tick();
    down_result_valid = 1'b0;
  endtask

  initial begin
    rst_n             = 1'b1;
    in_valid          = 1'b0;
    in_a              = '0;
    in_b              = '0;
    in_instr          = '0;
    in_last           = 1'b0;
    down_result_valid = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #2;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy",  32'(busy),     32'd0);
    check("rst_dv",    32'(data_valid), 32'd0);
    check("rst_a",     32'(A),        32'd0);
    check("rst_fc",    32'(frame_count), 32'd0);
    check("rst_err",   32'(err),      32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Three-word frame
    set_word(8'd5, 8'd3, 4'd0, 1'b0);
    tick();
    check("f1_nohdr_yet", 32'(data_valid), 32'd0);
    set_word(8'd9, 8'd1, 4'd0, 1'b0);
    tick();
    check_beat("f1_hdr", 8'd0, 8'd0, 4'd0, 1'b0);
    check("f1_hdr_busy", 32'(busy), 32'd1);
    set_word(8'd7, 8'd7, 4'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    check_beat("f1_b1", 8'd5, 8'd3, 4'd0, 1'b0);
    check("f1_b1_busy", 32'(busy), 32'd1);
    tick();
    check_beat("f1_b2", 8'd9, 8'd1, 4'd0, 1'b0);
    tick();
    check_beat("f1_b3", 8'd7, 8'd7, 4'd0, 1'b1);
    tick();
    check("f1_wait_dv",   32'(data_valid), 32'd0);
    check("f1_wait_last", 32'(last_data),  32'd0);
    check("f1_wait_busy", 32'(busy),       32'd1);

    // Queue a second frame during WAIT, then acknowledge 4 edges after the last beat
    set_word(8'd1, 8'd2, 4'd3, 1'b0);
    tick();
    set_word(8'd4, 8'd5, 4'd6, 1'b1);
    tick();
    in_valid          = 1'b0;
    check("f1_wait_hold_dv", 32'(data_valid), 32'd0);
    check("f1_fc_before",    32'(frame_count), 32'd0);
    pulse_result();
    check("f1_fc_after", 32'(frame_count), 32'd1);
    check("f1_idle",     32'(busy),        32'd0);
    check("f1_idle_dv",  32'(data_valid),  32'd0);
    tick();
    check_beat("f2_hdr", 8'd0, 8'd0, 4'd0, 1'b0);
    tick();
    check_beat("f2_b1", 8'd1, 8'd2, 4'd3, 1'b0);
    tick();
    check_beat("f2_b2", 8'd4, 8'd5, 4'd6, 1'b1);
    pulse_result();
    check("f2_fc", 32'(frame_count), 32'd2);

    // Fill the FIFO while held in WAIT
    set_word(8'hAA, 8'hBB, 4'hC, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    check_beat("f3_hdr", 8'd0, 8'd0, 4'd0, 1'b0);
    tick();
    check_beat("f3_b1", 8'hAA, 8'hBB, 4'hC, 1'b1);
    for (int i = 0; i < 8; i++) begin
      set_word(8'h10 + 8'(i), 8'h20 + 8'(i), 4'(i), (i == 7));
      tick();
      check("full_ready", 32'(in_ready), (i < 7) ? 32'd1 : 32'd0);
    end
    set_word(8'h99, 8'h99, 4'h9, 1'b0);
    tick();
    check("stall9_ready", 32'(in_ready),   32'd0);
    check("stall9_dv",    32'(data_valid), 32'd0);
    set_word(8'h9A, 8'h9A, 4'hA, 1'b1);
    tick();
    check("stall10_ready", 32'(in_ready), 32'd0);
    check("stall10_busy",  32'(busy),     32'd1);
    in_valid = 1'b0;
    pulse_result();
    check("f3_fc",    32'(frame_count), 32'd3);
    check("f3_ready", 32'(in_ready),    32'd0);
    tick();
    check_beat("f4_hdr", 8'd0, 8'd0, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_beat("f4_beat", 8'h10 + 8'(i), 8'h20 + 8'(i), 4'(i), (i == 7));
    end
    tick();
    check("f4_after_dv", 32'(data_valid), 32'd0);
    check("f4_ready",    32'(in_ready),   32'd1);
    pulse_result();
    check("f4_fc", 32'(frame_count), 32'd4);

    // Watchdog: no acknowledge
    set_word(8'h31, 8'h32, 4'h3, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check_beat("wd_b1", 8'h31, 8'h32, 4'h3, 1'b1);
    for (int i = 0; i < 15; i++) begin
      tick();
    end
    check("wd_err_pre",  32'(err),  32'd0);
    check("wd_busy_pre", 32'(busy), 32'd1);
    tick();
    check("wd_err",  32'(err),         32'd1);
    check("wd_idle", 32'(busy),        32'd0);
    check("wd_fc",   32'(frame_count), 32'd4);
    set_word(8'h41, 8'h42, 4'h4, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    check_beat("wd_next_hdr", 8'd0, 8'd0, 4'd0, 1'b0);
    tick();
    check_beat("wd_next_b1", 8'h41, 8'h42, 4'h4, 1'b1);
    pulse_result();
    check("wd_next_fc",  32'(frame_count), 32'd5);
    check("wd_err_stky", 32'(err),         32'd1);

    // Two-cycle gap inside a frame
    set_word(8'd11, 8'd12, 4'd1, 1'b0);
    tick();
    set_word(8'd13, 8'd14, 4'd2, 1'b0);
    tick();
    in_valid = 1'b0;
    check_beat("gap_hdr", 8'd0, 8'd0, 4'd0, 1'b0);
    tick();
    check_beat("gap_b1", 8'd11, 8'd12, 4'd1, 1'b0);
    tick();
    check_beat("gap_b2", 8'd13, 8'd14, 4'd2, 1'b0);
    tick();
    check("gap1_dv", 32'(data_valid),  32'd0);
    check("gap1_a",  32'(A),           32'd13);
    check("gap1_b",  32'(B),           32'd14);
    check("gap1_op", 32'(instruction), 32'd2);
    set_word(8'd15, 8'd16, 4'd3, 1'b1);
    tick();
    in_valid = 1'b0;
    check("gap2_dv",   32'(data_valid), 32'd0);
    check("gap2_a",    32'(A),          32'd13);
    check("gap2_busy", 32'(busy),       32'd1);
    tick();
    check_beat("gap_b3", 8'd15, 8'd16, 4'd3, 1'b1);
    pulse_result();
    check("gap_fc", 32'(frame_count), 32'd6);

    // Reset after the second beat of a four-word frame
    set_word(8'h51, 8'h61, 4'h1, 1'b0);
    tick();
    set_word(8'h52, 8'h62, 4'h2, 1'b0);
    tick();
    set_word(8'h53, 8'h63, 4'h3, 1'b0);
    tick();
    set_word(8'h54, 8'h64, 4'h4, 1'b1);
    tick();
    in_valid = 1'b0;
    check_beat("mr_b2", 8'h52, 8'h62, 4'h2, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mr_dv",    32'(data_valid),  32'd0);
    check("mr_a",     32'(A),           32'd0);
    check("mr_b",     32'(B),           32'd0);
    check("mr_op",    32'(instruction), 32'd0);
    check("mr_last",  32'(last_data),   32'd0);
    check("mr_fc",    32'(frame_count), 32'd0);
    check("mr_err",   32'(err),         32'd0);
    check("mr_busy",  32'(busy),        32'd0);
    check("mr_ready", 32'(in_ready),    32'd1);
    #2 rst_n = 1'b1;
    tick();
    tick();
    check("mr_post_dv",   32'(data_valid), 32'd0);
    check("mr_post_busy", 32'(busy),       32'd0);
    set_word(8'h71, 8'h72, 4'h7, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    check_beat("mr_new_hdr", 8'd0, 8'd0, 4'd0, 1'b0);
    tick();
    check_beat("mr_new_b1", 8'h71, 8'h72, 4'h7, 1'b1);
    pulse_result();
    check("mr_new_fc", 32'(frame_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
